pll_reset_sequencer: RTL and testbench
======================================

# pll_reset_sequencer

Reset and lock sequencer for the 25 MHz system PLL of the multicycle RISC-V core. It runs on the 50 MHz board reference clock and holds the PLL in reset for a fixed interval after board reset. It then waits for `locked`, qualifies it as stable, and only then releases the system reset. On lock loss it re-sequences; on repeated lock timeouts it enters a sticky failure state.

## Interface
Parameters:
- `RST_HOLD_CYCLES`, 16: refclk cycles `pll_rst` is held high on each attempt (≥1).
- `LOCK_TIMEOUT`, 50000: refclk cycles allowed in WAIT_LOCK before an attempt fails (1 ms at 50 MHz).
- `LOCK_STABLE_CYCLES`, 1024: consecutive cycles `locked` must stay high before reset release.
- `MAX_RETRIES`, 3: failed attempts before entering FAIL (≥1).
- `CNT_W`, 16: shared counter width; must hold the maximum of the three cycle parameters minus 1.

Ports:
- `refclk`, input, 1: 50 MHz reference clock; the only clock.
- `rst`, input, 1: synchronous, active-low reset.
- `pll_locked`, input, 1: PLL `locked` output; asynchronous to `refclk`.
- `restart`, input, 1: single-cycle request to re-sequence the PLL from HOLD.
- `pll_rst`, output, 1: drives the PLL `rst` input; active high.
- `sys_rst_n`, output, 1: system reset to the core; active low, in the `refclk` domain. The consumer re-synchronizes it.
- `lock_fail`, output, 1: high while in FAIL.
- `relock_count`, output, 8: number of lock losses seen in RUN; saturates at 255.
- `seq_state`, output, 3: current state encoding (HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4).

## Operation
- **Synchronizer.** `pll_locked` passes through a 2-flop synchronizer to produce `locked_s`. The synchronizer flops reset to 0.
- **Reset (`rst`=0 at an edge).** State becomes HOLD, counter 0, retry 0, `relock_count` 0. Outputs: `pll_rst`=1, `sys_rst_n`=0, `lock_fail`=0.
- **HOLD.** Counter increments. At counter = `RST_HOLD_CYCLES`-1, go to WAIT_LOCK and clear the counter.
- **WAIT_LOCK.**
  - If `locked_s`=1, go to STABLE and clear the counter.
  - Else, if counter = `LOCK_TIMEOUT`-1, increment retry. If the new retry = `MAX_RETRIES`, go to FAIL; otherwise go to HOLD. Clear the counter in both cases.
- **STABLE.**
  - If `locked_s`=0, go to WAIT_LOCK with counter 0. The timeout restarts and retry is unchanged.
  - Else, at counter = `LOCK_STABLE_CYCLES`-1, go to RUN and clear retry.
- **RUN.** If `locked_s`=0, go to HOLD with counter 0 and increment `relock_count` (saturating).
- **FAIL.** The block stays in FAIL until `restart` or `rst`.
- **`restart`=1.** In any state, go to HOLD with counter 0, retry 0, `lock_fail` cleared. `relock_count` is not incremented.
- **Priority.** `rst` > `restart` > lock/timeout events.
- **Output registers.** All outputs are registered and decoded from the next state:
  - `pll_rst` = 1 in HOLD or FAIL.
  - `sys_rst_n` = 1 only in RUN.
  - `lock_fail` = 1 only in FAIL.

## Timing
- After the first edge with `rst`=1, `pll_rst` stays high for exactly `RST_HOLD_CYCLES` cycles, then drops.
- `pll_locked` rising → `locked_s` high 2 cycles later → STABLE entered 1 cycle after that.
- `sys_rst_n` rises exactly 3 + `LOCK_STABLE_CYCLES` cycles after `pll_locked` rises, provided lock holds throughout.
- `pll_locked` falling in RUN → `sys_rst_n`=0 and `pll_rst`=1 exactly 3 cycles later.
- A glitch in `pll_locked` shorter than one cycle may be missed. A glitch held for ≥2 cycles is always seen.
- `restart` asserted at edge t → `pll_rst`=1 and `sys_rst_n`=0 from t+1.
- WAIT_LOCK timeout fires `LOCK_TIMEOUT` cycles after entry. Total time to FAIL from reset (lock never asserts) = `MAX_RETRIES`·(`RST_HOLD_CYCLES`+`LOCK_TIMEOUT`) cycles.
- `rst` mid-operation always wins at the next edge, including in FAIL.

## Test plan
Bench parameters: `RST_HOLD_CYCLES`=4, `LOCK_TIMEOUT`=20, `LOCK_STABLE_CYCLES`=8, `MAX_RETRIES`=2.

- **Clean bring-up.** Release `rst`; raise `pll_locked` 10 cycles later → `pll_rst` high for 4 cycles; `sys_rst_n` rises 11 cycles after `pll_locked` rises; `seq_state`=3.
- **Unstable lock.** `pll_locked` high for 5 cycles, low for 3, then high → returns to WAIT_LOCK; `sys_rst_n` rises 11 cycles after the final rise; retry unaffected.
- **Timeout to FAIL.** `pll_locked` held low → two HOLD(4)/WAIT_LOCK(20) attempts; FAIL entered 48 cycles after reset release; `lock_fail`=1, `pll_rst`=1, `sys_rst_n`=0.
- **Lock loss in RUN.** Drop `pll_locked` for 3 cycles → `sys_rst_n`=0 3 cycles later; `relock_count`=1; full re-sequence back to RUN. Repeat 300 losses → `relock_count` saturates at 255.
- **Restart and reset priority.** Pulse `restart` in FAIL → `lock_fail`=0, HOLD next cycle. Pulse `restart` in RUN → HOLD, `relock_count` unchanged. Assert `rst` and `restart` together → reset values, `relock_count`=0.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset hold, lock qualification and system reset release sequencer
//
// Ports:
//   refclk        in   reference clock, the only clock
//   rst           in   synchronous active-low reset
//   pll_locked    in   PLL locked indication, asynchronous to refclk
//   restart       in   single-cycle request to re-sequence from HOLD
//   pll_rst       out  PLL reset, active high (HOLD or FAIL)
//   sys_rst_n     out  system reset, active low, released only in RUN
//   lock_fail     out  high while in FAIL
//   relock_count  out  lock losses seen in RUN, saturating at 255
//   seq_state     out  current state (HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4)

module pll_reset_sequencer #(
    parameter int RST_HOLD_CYCLES    = 16,
    parameter int LOCK_TIMEOUT       = 50000,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES        = 3,
    parameter int CNT_W              = 16
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       lock_fail,
    output logic [7:0] relock_count,
    output logic [2:0] seq_state
);

    localparam logic [2:0] S_HOLD      = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAIL      = 3'd4;

    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    logic               sync1;
    logic               locked_s;
    logic [2:0]         state;
    logic [2:0]         state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nx;
    logic [RETRY_W-1:0] retry;
    logic [RETRY_W-1:0] retry_nx;
    logic               relock_inc;

    // Two-flop synchronizer for the asynchronous lock indication.
    always_ff @(posedge refclk) begin
        if (!rst) begin
            sync1    <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync1    <= pll_locked;
            locked_s <= sync1;
        end
    end

    // One counter is shared by all timed states; it is cleared on every
    // state change so each state measures its own dwell time.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt + CNT_W'(1);
        retry_nx   = retry;
        relock_inc = 1'b0;
        if (restart) begin
            state_nx = S_HOLD;
            cnt_nx   = '0;
            retry_nx = '0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state_nx = S_WAIT_LOCK;
                        cnt_nx   = '0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nx = S_STABLE;
                        cnt_nx   = '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt_nx   = '0;
                        retry_nx = retry + RETRY_W'(1);
                        state_nx = (retry_nx == RETRY_LIMIT) ? S_FAIL : S_HOLD;
                    end
                end
                S_STABLE: begin
                    // A dropout restarts the lock wait but does not count
                    // as a failed attempt.
                    if (!locked_s) begin
                        state_nx = S_WAIT_LOCK;
                        cnt_nx   = '0;
                    end else if (cnt == STABLE_LAST) begin
                        state_nx = S_RUN;
                        cnt_nx   = '0;
                        retry_nx = '0;
                    end
                end
                S_RUN: begin
                    cnt_nx = '0;
                    if (!locked_s) begin
                        state_nx   = S_HOLD;
                        relock_inc = 1'b1;
                    end
                end
                S_FAIL: begin
                    cnt_nx = '0;
                end
                default: begin
                    state_nx = S_HOLD;
                    cnt_nx   = '0;
                    retry_nx = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register, glitch-free.
    always_ff @(posedge refclk) begin
        if (!rst) begin
            state        <= S_HOLD;
            cnt          <= '0;
            retry        <= '0;
            relock_count <= 8'd0;
            pll_rst      <= 1'b1;
            sys_rst_n    <= 1'b0;
            lock_fail    <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            retry     <= retry_nx;
            pll_rst   <= (state_nx == S_HOLD) || (state_nx == S_FAIL);
            sys_rst_n <= (state_nx == S_RUN);
            lock_fail <= (state_nx == S_FAIL);
            if (relock_inc && (relock_count != 8'hFF)) begin
                relock_count <= relock_count + 8'd1;
            end
        end
    end

    assign seq_state = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - self-checking bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

    localparam int RHC = 4;
    localparam int LT  = 20;
    localparam int LSC = 8;
    localparam int MR  = 2;

    logic       refclk = 1'b0;
    logic       rst = 1'b0;
    logic       pll_locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       lock_fail;
    logic [7:0] relock_count;
    logic [2:0] seq_state;

    int errors = 0;
    int checks = 0;

    pll_reset_sequencer #(
        .RST_HOLD_CYCLES   (RHC),
        .LOCK_TIMEOUT      (LT),
        .LOCK_STABLE_CYCLES(LSC),
        .MAX_RETRIES       (MR),
        .CNT_W             (16)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .restart     (restart),
        .pll_rst     (pll_rst),
        .sys_rst_n   (sys_rst_n),
        .lock_fail   (lock_fail),
        .relock_count(relock_count),
        .seq_state   (seq_state)
    );

    always #5 refclk = ~refclk;

    // Reference model: phase + time spent in phase, lock seen two samples late.
    typedef enum int {M_HOLD = 0, M_WAIT = 1, M_STABLE = 2, M_RUN = 3, M_FAIL = 4} phase_t;
    phase_t m_phase = M_HOLD;
    int     m_age = 0;
    int     m_fails = 0;
    int     m_relocks = 0;
    logic   m_seen_q[2] = '{1'b0, 1'b0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic rs, input logic lk);
        logic seen;
        seen = m_seen_q[1];
        if (!r) begin
            m_seen_q  = '{1'b0, 1'b0};
            m_phase   = M_HOLD;
            m_age     = 0;
            m_fails   = 0;
            m_relocks = 0;
            return;
        end
        m_seen_q[1] = m_seen_q[0];
        m_seen_q[0] = lk;
        if (rs) begin
            m_phase = M_HOLD;
            m_age   = 0;
            m_fails = 0;
            return;
        end
        m_age++;
        case (m_phase)
            M_HOLD: if (m_age == RHC) begin m_phase = M_WAIT; m_age = 0; end
            M_WAIT: begin
                if (seen) begin
                    m_phase = M_STABLE; m_age = 0;
                end else if (m_age == LT) begin
                    m_fails++;
                    m_phase = (m_fails == MR) ? M_FAIL : M_HOLD;
                    m_age = 0;
                end
            end
            M_STABLE: begin
                if (!seen) begin
                    m_phase = M_WAIT; m_age = 0;
                end else if (m_age == LSC) begin
                    m_phase = M_RUN; m_age = 0; m_fails = 0;
                end
            end
            M_RUN: if (!seen) begin
                m_phase = M_HOLD; m_age = 0;
                if (m_relocks < 255) m_relocks++;
            end
            default: m_age = 0;
        endcase
    endtask

    function automatic logic [13:0] model_outputs();
        logic [7:0] rc;
        logic [2:0] st;
        rc = 8'(m_relocks);
        st = 3'(int'(m_phase));
        return {(m_phase == M_HOLD) || (m_phase == M_FAIL), m_phase == M_RUN,
                m_phase == M_FAIL, rc, st};
    endfunction

    task automatic tick();
        logic r, rs, lk;
        r = rst; rs = restart; lk = pll_locked;
        @(posedge refclk);
        #1;
        model_step(r, rs, lk);
        check("model", {18'd0, pll_rst, sys_rst_n, lock_fail, relock_count, seq_state},
              {18'd0, model_outputs()});
    endtask

    task automatic do_reset();
        rst = 1'b0;
        restart = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    typedef struct {
        logic       rst;
        logic       restart;
        logic       locked;
        logic       pll_rst;
        logic       sys_rst_n;
        logic       lock_fail;
        logic [2:0] state;
    } vec_t;

    vec_t tbl[18];
    int   n;
    int   hold_left;

    initial begin
        // Lock present from the start: HOLD 4, one WAIT cycle, STABLE 8, RUN,
        // then restart, then rst together with restart.
        tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
        for (int i = 1; i <= 3; i++) tbl[i] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1};
        for (int i = 5; i <= 12; i++) tbl[i] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};

        for (int i = 0; i < 18; i++) begin
            rst        = tbl[i].rst;
            restart    = tbl[i].restart;
            pll_locked = tbl[i].locked;
            tick();
            check($sformatf("vec%0d", i), {26'd0, pll_rst, sys_rst_n, lock_fail, seq_state},
                  {26'd0, tbl[i].pll_rst, tbl[i].sys_rst_n, tbl[i].lock_fail, tbl[i].state});
        end

        // Clean bring-up.
        pll_locked = 1'b0;
        do_reset();
        n = 0;
        while (pll_rst && n < 50) begin tick(); n++; end
        check("hold_len", n, RHC);
        repeat (10 - RHC) tick();
        pll_locked = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!sys_rst_n && n < 100);
        check("bringup_latency", n, 3 + LSC);
        check("bringup_state", seq_state, 3);

        // Unstable lock.
        pll_locked = 1'b0;
        do_reset();
        repeat (6) tick();
        pll_locked = 1'b1;
        repeat (5) tick();
        pll_locked = 1'b0;
        repeat (3) tick();
        check("unstable_back_to_wait", seq_state, 1);
        pll_locked = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!sys_rst_n && n < 100);
        check("unstable_latency", n, 3 + LSC);

        // Timeout to FAIL.
        pll_locked = 1'b0;
        do_reset();
        n = 0;
        while (!lock_fail && n < 200) begin tick(); n++; end
        check("fail_time", n, MR * (RHC + LT));
        check("fail_pll_rst", pll_rst, 1);
        check("fail_sys_rst_n", sys_rst_n, 0);
        check("fail_state", seq_state, 4);
        pll_locked = 1'b1;
        repeat (10) tick();
        check("fail_sticky", {lock_fail, seq_state}, {1'b1, 3'd4});

        // Restart out of FAIL.
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("restart_fail_clear", {lock_fail, pll_rst, seq_state}, {1'b0, 1'b1, 3'd0});

        // Lock loss in RUN.
        n = 0;
        while (!sys_rst_n && n < 100) begin tick(); n++; end
        check("run_reached", sys_rst_n, 1);
        pll_locked = 1'b0;
        n = 0;
        do begin tick(); n++; end while (sys_rst_n && n < 20);
        check("loss_latency", n, 3);
        check("loss_pll_rst", pll_rst, 1);
        check("relock_one", relock_count, 1);
        for (int k = 0; k < 299; k++) begin
            pll_locked = 1'b1;
            n = 0;
            while (!sys_rst_n && n < 100) begin tick(); n++; end
            check("rerun", sys_rst_n, 1);
            pll_locked = 1'b0;
            repeat (3) tick();
        end
        pll_locked = 1'b1;
        n = 0;
        while (!sys_rst_n && n < 100) begin tick(); n++; end
        check("relock_saturated", relock_count, 255);

        // Restart in RUN keeps the relock count.
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("restart_run", {sys_rst_n, pll_rst, seq_state}, {1'b0, 1'b1, 3'd0});
        check("restart_run_relock", relock_count, 255);

        // rst wins over restart.
        rst = 1'b0;
        restart = 1'b1;
        tick();
        check("rst_restart_relock", relock_count, 0);
        check("rst_restart_out", {pll_rst, sys_rst_n, lock_fail, seq_state}, {1'b1, 1'b0, 1'b0, 3'd0});
        rst = 1'b1;
        restart = 1'b0;

        // Randomized lock behaviour against the model.
        hold_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold_left == 0) begin
                pll_locked = ~pll_locked;
                hold_left = $urandom_range(1, 60);
            end
            hold_left--;
            restart = ($urandom_range(0, 149) == 0);
            rst     = ($urandom_range(0, 399) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
